// File: rtl/rotate_shift_pkg.sv
// Shared definitions for the pipelined rotator/shifter.
//   OP_*        : operation encodings carried on in_op
//   MAX_WIDTH   : widest data path that bit_rev can handle
//   bit_rev     : reverses the low w bits of a vector (upper bits return 0)
//   stage_count : register stages for a given amount width and layer grouping
package rotate_shift_pkg;

  localparam logic [1:0] OP_ROTR = 2'b00;
  localparam logic [1:0] OP_ROTL = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  localparam int MAX_WIDTH = 128;

  function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] d,
                                                   input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[i] = d[w-1-i];
    end
    return r;
  endfunction

  function automatic int stage_count(input int amt_w, input int reg_every);
    return (amt_w + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/rot_layer.sv
// One conditional rotate-right-by-DIST layer of the barrel network.
//   d         : layer input
//   en        : apply this layer (the matching amount bit)
//   zero_fill : clear the DIST bits that wrap around (shift instead of rotate)
//   q         : layer output
module rot_layer #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             zero_fill,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] rotated;
  logic [WIDTH-1:0] fill_mask;

  assign rotated   = {d[DIST-1:0], d[WIDTH-1:DIST]};
  // Ones everywhere except the top DIST bits, which received wrapped data.
  assign fill_mask = {WIDTH{1'b1}} >> DIST;
  assign q         = !en ? d : (zero_fill ? (rotated & fill_mask) : rotated);

endmodule

// File: rtl/rotate_shift_pipe.sv
// Pipelined barrel rotator/shifter (ROTR/ROTL/SHR/SHL) with valid/ready
// streaming and a sideband tag.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready         : input handshake
//   in_data, in_amt, in_op    : operand, distance, operation
//   in_tag                    : sideband returned with the result
//   out_valid/out_ready       : output handshake
//   out_data, out_tag         : result and its tag
// Layers run from the largest distance down; REG_EVERY layers sit between
// consecutive registers. Left ops reverse the operand on entry and reverse
// the result again just before the last register, so only right moves exist
// in the network.
module rotate_shift_pipe
  import rotate_shift_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int REG_EVERY = 1,
  parameter  int TAG_W     = 4,
  localparam int AMT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int P = stage_count(AMT_W, REG_EVERY);

  function automatic logic is_left(input logic [1:0] op);
    return (op == OP_ROTL) || (op == OP_SHL);
  endfunction

  function automatic logic is_shift(input logic [1:0] op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

  logic [P-1:0]     st_valid;
  logic [WIDTH-1:0] st_data [P];
  logic [AMT_W-1:0] st_amt  [P];
  logic [1:0]       st_op   [P];
  logic [TAG_W-1:0] st_tag  [P];

  logic [P-1:0]     sin_valid;
  logic [WIDTH-1:0] sin_data [P];
  logic [AMT_W-1:0] sin_amt  [P];
  logic [1:0]       sin_op   [P];
  logic [TAG_W-1:0] sin_tag  [P];
  logic [WIDTH-1:0] sout_data [P];

  logic [P-1:0]     load;

  for (genvar s = 0; s < P; s++) begin : g_stage
    localparam int J0 = s * REG_EVERY;
    localparam int NL = ((AMT_W - J0) < REG_EVERY) ? (AMT_W - J0) : REG_EVERY;

    logic [WIDTH-1:0] chain [NL+1];

    if (s == 0) begin : g_entry
      assign sin_valid[s] = in_valid;
      assign sin_data[s]  = is_left(in_op) ?
                            WIDTH'(bit_rev(MAX_WIDTH'(in_data), WIDTH)) : in_data;
      assign sin_amt[s]   = in_amt;
      assign sin_op[s]    = in_op;
      assign sin_tag[s]   = in_tag;
    end else begin : g_link
      assign sin_valid[s] = st_valid[s-1];
      assign sin_data[s]  = st_data[s-1];
      assign sin_amt[s]   = st_amt[s-1];
      assign sin_op[s]    = st_op[s-1];
      assign sin_tag[s]   = st_tag[s-1];
    end

    assign chain[0] = sin_data[s];

    for (genvar k = 0; k < NL; k++) begin : g_layer
      localparam int LI = AMT_W - 1 - (J0 + k);
      rot_layer #(
        .WIDTH (WIDTH),
        .DIST  (1 << LI)
      ) u_layer (
        .d         (chain[k]),
        .en        (sin_amt[s][LI]),
        .zero_fill (is_shift(sin_op[s])),
        .q         (chain[k+1])
      );
    end

    if (s == P - 1) begin : g_exit
      assign sout_data[s] = is_left(sin_op[s]) ?
                            WIDTH'(bit_rev(MAX_WIDTH'(chain[NL]), WIDTH)) : chain[NL];
    end else begin : g_mid
      assign sout_data[s] = chain[NL];
    end
  end

  // A stage loads when empty or when the stage after it is loading; the last
  // stage looks at out_ready. Walking backwards lets a bubble anywhere pull
  // everything upstream of it forward in the same cycle.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    load = '0;
    for (int s = P - 1; s >= 0; s--) begin
      load[s] = !st_valid[s] || nxt;
      nxt     = load[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      for (int s = 0; s < P; s++) begin
        st_data[s] <= '0;
        st_amt[s]  <= '0;
        st_op[s]   <= '0;
        st_tag[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < P; s++) begin
        if (load[s]) begin
          st_valid[s] <= sin_valid[s];
          // Payload only moves with a real beat so idle outputs stay put.
          if (sin_valid[s]) begin
            st_data[s] <= sout_data[s];
            st_amt[s]  <= sin_amt[s];
            st_op[s]   <= sin_op[s];
            st_tag[s]  <= sin_tag[s];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = st_valid[P-1];
  assign out_data  = st_data[P-1];
  assign out_tag   = st_tag[P-1];

endmodule

// File: tb/tb_rotate_shift_pipe.sv
module tb_rotate_shift_pipe;
  import rotate_shift_pkg::*;

  localparam int W   = 32;
  localparam int P32 = 5;
  localparam int W64 = 64;
  localparam int P64 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] in_data64, out_data64;
  logic [5:0]  in_amt64;
  logic [1:0]  in_op64;
  logic [3:0]  in_tag64, out_tag64;

  rotate_shift_pipe #(.WIDTH(W), .REG_EVERY(1), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  rotate_shift_pipe #(.WIDTH(W64), .REG_EVERY(2), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_data(in_data64),
    .in_amt(in_amt64), .in_op(in_op64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_data(out_data64), .out_tag(out_tag64)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_ready = 1'b0;
  int   run_len = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit-by-bit reference, independent of the layer structure.
  function automatic logic [63:0] ref_model(input logic [63:0] d, input int a,
                                            input logic [1:0] op, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        OP_ROTR: r[i] = d[(i + a) % w];
        OP_ROTL: r[i] = d[(i - a + w) % w];
        OP_SHR:  r[i] = (i + a < w) ? d[i + a] : 1'b0;
        default: r[i] = (i >= a) ? d[i - a] : 1'b0;
      endcase
    end
    return r;
  endfunction

  // Output monitor: every valid cycle must show the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (sb.size() == 0) begin
        chk("idle_valid", 64'(out_valid), 64'd0);
      end else if (out_valid) begin
        chk("out_data", 64'(out_data), sb[0].data);
        chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                      input logic [3:0] t, input logic [31:0] exp);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = op;
    in_tag   = t;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back('{64'(exp), t});
      @(posedge clk);
      #1;
      guard++;
    end
    chk("send_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic rand_beat();
    logic [31:0] d;
    logic [4:0]  a;
    logic [1:0]  op;
    logic [3:0]  t;
    d  = $urandom;
    a  = 5'($urandom_range(0, 31));
    op = 2'($urandom_range(0, 3));
    t  = 4'($urandom_range(0, 15));
    send(d, a, op, t, 32'(ref_model(64'(d), int'(a), op, W)));
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send64(input logic [63:0] d, input logic [5:0] a, input logic [1:0] op,
                        input logic [3:0] t, input logic [63:0] exp);
    int lat;
    in_valid64 = 1'b1;
    in_data64  = d;
    in_amt64   = a;
    in_op64    = op;
    in_tag64   = t;
    @(negedge clk);
    chk("in_ready64", 64'(in_ready64), 64'd1);
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    lat = 1;
    while (!out_valid64 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lat64", 64'(lat), 64'(P64));
    chk("data64", out_data64, exp);
    chk("tag64", 64'(out_tag64), 64'(t));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int accepts;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    in_valid64 = 1'b0; in_data64 = '0; in_amt64 = '0; in_op64 = '0; in_tag64 = '0;
    out_ready64 = 1'b1;
    #23 rst_n = 1'b1;

    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors and latency
    send(32'h8000_0001, 5'd1, OP_ROTR, 4'hA, 32'hC000_0000);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lat32", 64'(lat), 64'(P32));
    wait_drain();

    send(32'h1234_5678, 5'd7,  OP_ROTR, 4'h5, 32'hF024_68AC);
    send(32'h8000_0001, 5'd4,  OP_ROTL, 4'h6, 32'h0000_0018);
    send(32'hF000_0000, 5'd28, OP_SHR,  4'h7, 32'h0000_000F);
    send(32'h0000_FFFF, 5'd16, OP_SHL,  4'h8, 32'hFFFF_0000);
    send(32'hDEAD_BEEF, 5'd0,  OP_ROTR, 4'h1, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  OP_ROTL, 4'h2, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  OP_SHR,  4'h3, 32'hDEAD_BEEF);
    send(32'hDEAD_BEEF, 5'd0,  OP_SHL,  4'h4, 32'hDEAD_BEEF);
    send(32'h8000_0001, 5'd31, OP_SHL,  4'h9, 32'h8000_0000);
    wait_drain();

    // Back-to-back with the consumer always ready
    max_run = 0;
    for (int i = 0; i < 20; i++) rand_beat();
    wait_drain();
    chk("b2b_run", 64'(max_run), 64'd20);

    // Random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) rand_beat();
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    // Fill against a stalled consumer, then drain
    out_ready = 1'b0;
    accepts = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = $urandom;
      in_amt  = 5'($urandom_range(0, 31));
      in_op   = 2'($urandom_range(0, 3));
      in_tag  = 4'(i);
      @(negedge clk);
      if (!in_ready) break;
      sb.push_back('{ref_model(64'(in_data), int'(in_amt), in_op, W), in_tag});
      accepts++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("fill_accepts", 64'(accepts), 64'(P32));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < P32; i++) begin
      @(negedge clk);
      chk("drain_valid", 64'(out_valid), 64'd1);
    end
    wait_drain();

    // Reset with beats in flight
    out_ready = 1'b0;
    send(32'hA5A5_A5A5, 5'd0, OP_ROTR, 4'hB, 32'hA5A5_A5A5);
    send(32'h0F0F_0F0F, 5'd4, OP_ROTL, 4'hC, 32'hF0F0_F0F0);
    send(32'h1111_1111, 5'd1, OP_SHR,  4'hD, 32'h0888_8888);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_data", 64'(out_data), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 64-bit, two layers per register stage
    send64(64'h1, 6'd63, OP_ROTR, 4'h3, 64'h2);
    send64(64'h8000_0000_0000_0000, 6'd63, OP_SHR, 4'h4, 64'h1);
    send64(64'h0123_4567_89AB_CDEF, 6'd8, OP_ROTL, 4'h5, 64'h2345_6789_ABCD_EF01);
    send64(64'h0123_4567_89AB_CDEF, 6'd0, OP_SHL, 4'h6, 64'h0123_4567_89AB_CDEF);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 6'd36, OP_SHL, 4'h7, 64'hFFFF_FFF0_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
